// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Port 0 is the data (load/store) port, port 1 the instruction-fetch port.
// Round-robin with a bounded burst: the current owner keeps the RAM while it
// requests, until it has had BURST_LEN grants in a row and the other port waits.
//
// state | meaning
// IDLE  | no grant last cycle; ties go to the port that was not granted last
// OWN0  | port 0 was granted last cycle; cnt counts its consecutive grants
// OWN1  | port 1 was granted last cycle; cnt counts its consecutive grants
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic                  ack0,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] din1,
   output logic                  ack1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam logic [3:0] BURST = 4'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

   owner_t     owner, owner_nxt;
   logic       last, last_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       rpend0, rpend0_nxt;
   logic       rpend1, rpend1_nxt;
   logic       gnt;
   logic       gsel;

   // Grant decision and next-state computation.
   always_comb begin
      gnt        = 1'b0;
      gsel       = 1'b0;
      owner_nxt  = IDLE;
      last_nxt   = last;
      cnt_nxt    = 4'd0;
      rpend0_nxt = 1'b0;
      rpend1_nxt = 1'b0;

      case (owner)
         IDLE: begin
            if (req0 && req1) begin
               gnt  = 1'b1;
               gsel = ~last;
            end else if (req0) begin
               gnt  = 1'b1;
               gsel = 1'b0;
            end else if (req1) begin
               gnt  = 1'b1;
               gsel = 1'b1;
            end
         end
         OWN0: begin
            if (req0 && (!req1 || cnt < BURST)) begin
               gnt  = 1'b1;
               gsel = 1'b0;
            end else if (req1) begin
               gnt  = 1'b1;
               gsel = 1'b1;
            end
         end
         OWN1: begin
            if (req1 && (!req0 || cnt < BURST)) begin
               gnt  = 1'b1;
               gsel = 1'b1;
            end else if (req0) begin
               gnt  = 1'b1;
               gsel = 1'b0;
            end
         end
         default: ;
      endcase

      if (gnt) begin
         owner_nxt = gsel ? OWN1 : OWN0;
         last_nxt  = gsel;
         // From IDLE cnt is already 0, so a repeat of 'last' still restarts at 1.
         if (owner == owner_nxt)
            cnt_nxt = (cnt >= BURST) ? BURST : cnt + 4'd1;
         else
            cnt_nxt = 4'd1;
         rpend0_nxt = ~gsel & ~we0;
         rpend1_nxt = gsel & ~we1;
      end
   end

   // State register; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner  <= IDLE;
         last   <= 1'b1;
         cnt    <= 4'd0;
         rpend0 <= 1'b0;
         rpend1 <= 1'b0;
      end else begin
         owner  <= owner_nxt;
         last   <= last_nxt;
         cnt    <= cnt_nxt;
         rpend0 <= rpend0_nxt;
         rpend1 <= rpend1_nxt;
      end
   end

   // RAM steering; with no grant the port 0 lines pass through as a harmless read.
   always_comb begin
      ack0     = gnt & ~gsel & ~rst;
      ack1     = gnt & gsel & ~rst;
      ram_we   = gnt & ~rst & (gsel ? we1 : we0);
      ram_addr = (gnt && gsel) ? addr1 : addr0;
      ram_din  = (gnt && gsel) ? din1 : din0;
      rvalid0  = rpend0;
      rvalid1  = rpend1;
      rdata0   = ram_dout;
      rdata1   = ram_dout;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 4096x16 RAM behind it.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, we0, req1, we1;
   logic [11:0] addr0, addr1;
   logic [15:0] din0, din1;
   logic        ack0, ack1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;

   logic [15:0] mem [0:4095];

   int checks   = 0;
   int failures = 0;

   ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .BURST_LEN(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .we0      (we0),
      .addr0    (addr0),
      .din0     (din0),
      .ack0     (ack0),
      .rvalid0  (rvalid0),
      .rdata0   (rdata0),
      .req1     (req1),
      .we1      (we1),
      .addr1    (addr1),
      .din1     (din1),
      .ack1     (ack1),
      .rvalid1  (rvalid1),
      .rdata1   (rdata1),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM with registered read data.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      bit t4_r0 [7] = '{1, 1, 0, 1, 1, 1, 1};
      bit t4_r1 [7] = '{0, 1, 1, 1, 1, 1, 1};
      bit t4_a0 [7] = '{1, 1, 0, 0, 0, 0, 1};
      bit t4_a1 [7] = '{0, 0, 1, 1, 1, 1, 0};
      logic e0, e1, pe0, pe1;

      for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 + 16'(i);

      // Reset with both ports trying to write: nothing may leak out.
      rst = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h055; din0 = 16'h1234;
      req1 = 1'b1; we1 = 1'b1; addr1 = 12'h066; din1 = 16'h5678;
      mid();
      chk1("rst_ack0", ack0, 1'b0);
      chk1("rst_ack1", ack1, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chk1("rst_rvalid0", rvalid0, 1'b0);
      chk1("rst_rvalid1", rvalid1, 1'b0);
      step();
      step();
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      mid();
      chk1("idle_ack0", ack0, 1'b0);
      chk1("idle_ram_we", ram_we, 1'b0);

      // Port 0 write 0xBEEF to 0x123, then read it back.
      step();
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h123; din0 = 16'hBEEF;
      mid();
      chk1("t1_wr_ack0", ack0, 1'b1);
      chk1("t1_wr_ack1", ack1, 1'b0);
      chk1("t1_wr_ram_we", ram_we, 1'b1);
      chk16("t1_wr_ram_addr", 16'(ram_addr), 16'h0123);
      chk16("t1_wr_ram_din", ram_din, 16'hBEEF);
      step();
      we0 = 1'b0;
      mid();
      chk1("t1_rd_ack0", ack0, 1'b1);
      chk1("t1_rd_ram_we", ram_we, 1'b0);
      chk1("t1_rd_no_rvalid_for_write", rvalid0, 1'b0);
      step();
      req0 = 1'b0;
      mid();
      chk1("t1_rvalid0", rvalid0, 1'b1);
      chk16("t1_rdata0", rdata0, 16'hBEEF);
      chk1("t1_rvalid1", rvalid1, 1'b0);
      chk1("t1_ack0_dropped", ack0, 1'b0);

      // Both ports stream reads from reset: 4 grants each in turn.
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
      pe0 = 1'b0; pe1 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         e0 = (k <= 4) || (k >= 9);
         e1 = !e0;
         mid();
         chk1($sformatf("t2_ack0_c%0d", k), ack0, e0);
         chk1($sformatf("t2_ack1_c%0d", k), ack1, e1);
         chk1($sformatf("t2_rvalid0_c%0d", k), rvalid0, pe0);
         chk1($sformatf("t2_rvalid1_c%0d", k), rvalid1, pe1);
         pe0 = e0; pe1 = e1;
         step();
      end
      req0 = 1'b0; req1 = 1'b0;
      mid();
      chk1("t2_tail_rvalid0", rvalid0, 1'b1);
      chk16("t2_tail_rdata0", rdata0, 16'hA010);
      chk1("t2_tail_ack0", ack0, 1'b0);

      // Port 1 streams 10 reads alone: no stall when cnt saturates.
      for (int i = 0; i <= 10; i++) begin
         step();
         if (i < 10) begin
            req1 = 1'b1; we1 = 1'b0; addr1 = 12'(i);
         end else begin
            req1 = 1'b0;
         end
         mid();
         if (i < 10) chk1($sformatf("t3_ack1_%0d", i), ack1, 1'b1);
         if (i > 0) begin
            chk1($sformatf("t3_rvalid1_%0d", i - 1), rvalid1, 1'b1);
            chk16($sformatf("t3_rdata1_%0d", i - 1), rdata1, 16'hA000 + 16'(i - 1));
         end
      end

      // Port 0 drops after 2 grants; port 1 then gets a fresh burst of 4.
      addr0 = 12'h005; addr1 = 12'h006; we0 = 1'b0; we1 = 1'b0;
      for (int c = 0; c < 7; c++) begin
         step();
         req0 = t4_r0[c]; req1 = t4_r1[c];
         mid();
         chk1($sformatf("t4_ack0_c%0d", c + 1), ack0, t4_a0[c]);
         chk1($sformatf("t4_ack1_c%0d", c + 1), ack1, t4_a1[c]);
      end
      step();
      req0 = 1'b0; req1 = 1'b0;
      mid();

      // Port 0 writes 0x0F0F to 0x7FF, port 1 reads it on the next cycle.
      step();
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h7FF; din0 = 16'h0F0F;
      mid();
      chk1("t5_ack0", ack0, 1'b1);
      chk1("t5_ram_we", ram_we, 1'b1);
      step();
      req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 12'h7FF;
      mid();
      chk1("t5_ack1", ack1, 1'b1);
      chk16("t5_ram_addr", 16'(ram_addr), 16'h07FF);
      chk1("t5_rd_ram_we", ram_we, 1'b0);
      step();
      req1 = 1'b0;
      mid();
      chk1("t5_rvalid1", rvalid1, 1'b1);
      chk16("t5_rdata1", rdata1, 16'h0F0F);
      chk1("t5_rvalid0", rvalid0, 1'b0);

      // Reset right after a port 1 read ack kills the pending rvalid.
      step();
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h003;
      mid();
      chk1("t6_ack1", ack1, 1'b1);
      step();
      rst = 1'b1; req1 = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 12'h004; din0 = 16'h4444;
      #1;
      chk1("t6_rst_rvalid1", rvalid1, 1'b0);
      chk1("t6_rst_ram_we", ram_we, 1'b0);
      chk1("t6_rst_ack0", ack0, 1'b0);
      mid();
      chk1("t6_rst_rvalid1_hold", rvalid1, 1'b0);
      step();
      step();
      rst = 1'b0; req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
      mid();
      chk1("t6_post_ack0", ack0, 1'b1);
      chk1("t6_post_ack1", ack1, 1'b0);
      step();
      req0 = 1'b0; req1 = 1'b0;
      mid();
      chk1("t6_post_rvalid0", rvalid0, 1'b1);
      chk16("t6_post_rdata0", rdata0, 16'hA004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
